// File: rtl/ext_irq_arbiter.sv
// ext_irq_arbiter
// Front end of the machine controller's external-interrupt path. Each raw
// IRQ line passes through its own synchroniser and is latched as pending,
// either on a rising edge or while the level is high. The enabled pending
// sources are arbitrated by fixed priority, where the lowest index wins.
// The winner is presented to the controller as a registered meip/vecto_no
// pair. A claim/complete handshake tracks the interrupt under service:
// trap entry claims the request and mret completes it.
//
// Ports
//   i_clk         clock
//   i_rst_n       asynchronous active-low reset
//   i_irq_src     raw asynchronous interrupt lines, active-high
//   i_irq_en      per-source enable mask (affects arbitration only)
//   i_level_mode  1 = level-sensitive, 0 = rising-edge, per source
//   i_claim       one-cycle pulse: trap taken for the external interrupt
//   i_complete    one-cycle pulse: handler returned (mret)
//   o_meip        external interrupt request (high exactly in REQUEST)
//   o_vecto_no    winning source ID 1..N_SRC, 0 = none
//   o_in_service  a claimed interrupt is being serviced
//   o_isr_id      ID latched at claim, 0 when not in service
//   o_pending     raw pending bits for debug/CSR readback
module ext_irq_arbiter #(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_irq_src,
    input  logic [N_SRC-1:0] i_irq_en,
    input  logic [N_SRC-1:0] i_level_mode,
    input  logic             i_claim,
    input  logic             i_complete,
    output logic             o_meip,
    output logic [3:0]       o_vecto_no,
    output logic             o_in_service,
    output logic [3:0]       o_isr_id,
    output logic [N_SRC-1:0] o_pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Return the ID of the lowest-index set bit (index k gives ID k+1),
    // or 0 when no bit is set.
    function automatic logic [3:0] pick_winner(input logic [N_SRC-1:0] cand);
        logic [3:0] id;
        id = 4'd0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (cand[k]) begin
                id = 4'(k + 1);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    // Decode a source ID (1..N_SRC) into a one-hot source mask. ID 0 gives
    // an empty mask.
    function automatic logic [N_SRC-1:0] id_to_mask(input logic [3:0] id);
        logic [N_SRC-1:0] m;
        m = '0;
        for (int k = 0; k < N_SRC; k++) begin
            m[k] = (id == 4'(k + 1));
        end
        return m;
    endfunction

    logic [N_SRC-1:0] sync_r [SYNC_STAGES];
    logic [N_SRC-1:0] prev_r;
    logic [N_SRC-1:0] pending_r;
    state_t           state_r;
    logic             meip_r;
    logic [3:0]       vecto_r;
    logic             in_service_r;
    logic [3:0]       isr_id_r;

    logic [N_SRC-1:0] sync_s;
    logic [N_SRC-1:0] set_s;
    logic [N_SRC-1:0] clr_s;
    logic [N_SRC-1:0] excl_s;
    logic [N_SRC-1:0] cand_s;
    logic [N_SRC-1:0] pending_nxt_s;
    logic [3:0]       win_s;
    logic             claim_ok_s;
    state_t           state_nxt_s;
    logic             meip_nxt_s;
    logic [3:0]       vecto_nxt_s;
    logic             in_service_nxt_s;
    logic [3:0]       isr_id_nxt_s;

    // Per-source synchroniser chain. Only the last stage is used downstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= i_irq_src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Pending set/clear, candidate masking and fixed-priority winner.
    always_comb begin
        sync_s     = sync_r[SYNC_STAGES-1];
        set_s      = (i_level_mode & sync_s) | (~i_level_mode & sync_s & ~prev_r);
        claim_ok_s = (state_r == ST_REQUEST) && i_claim;
        if (claim_ok_s) begin
            clr_s = id_to_mask(vecto_r);
        end else begin
            clr_s = '0;
        end
        // A set wins over a clear, so an edge that arrives with its own
        // claim is retained.
        pending_nxt_s = (pending_r & ~clr_s) | set_s;
        if (state_r == ST_SERVICE) begin
            excl_s = id_to_mask(isr_id_r);
        end else begin
            excl_s = '0;
        end
        cand_s = pending_r & i_irq_en & ~excl_s;
        win_s  = pick_winner(cand_s);
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_nxt_s      = state_r;
        meip_nxt_s       = 1'b0;
        vecto_nxt_s      = 4'd0;
        in_service_nxt_s = in_service_r;
        isr_id_nxt_s     = isr_id_r;
        case (state_r)
            ST_IDLE: begin
                in_service_nxt_s = 1'b0;
                isr_id_nxt_s     = 4'd0;
                if (cand_s != '0) begin
                    state_nxt_s = ST_REQUEST;
                    meip_nxt_s  = 1'b1;
                    vecto_nxt_s = win_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                // A claim wins even if the candidates vanished this cycle.
                // The registered vector is the one the controller acted on.
                if (i_claim) begin
                    state_nxt_s      = ST_SERVICE;
                    vecto_nxt_s      = vecto_r;
                    in_service_nxt_s = 1'b1;
                    isr_id_nxt_s     = vecto_r;
                end else if (cand_s != '0) begin
                    state_nxt_s = ST_REQUEST;
                    meip_nxt_s  = 1'b1;
                    vecto_nxt_s = win_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (i_complete) begin
                    state_nxt_s      = ST_IDLE;
                    in_service_nxt_s = 1'b0;
                    isr_id_nxt_s     = 4'd0;
                end else begin
                    state_nxt_s = ST_SERVICE;
                    vecto_nxt_s = vecto_r;
                end
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                in_service_nxt_s = 1'b0;
                isr_id_nxt_s     = 4'd0;
            end
        endcase
    end

    // State, edge history, pending bits and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            prev_r       <= '0;
            pending_r    <= '0;
            meip_r       <= 1'b0;
            vecto_r      <= 4'd0;
            in_service_r <= 1'b0;
            isr_id_r     <= 4'd0;
        end else begin
            state_r      <= state_nxt_s;
            prev_r       <= sync_s;
            pending_r    <= pending_nxt_s;
            meip_r       <= meip_nxt_s;
            vecto_r      <= vecto_nxt_s;
            in_service_r <= in_service_nxt_s;
            isr_id_r     <= isr_id_nxt_s;
        end
    end

    assign o_meip       = meip_r;
    assign o_vecto_no   = vecto_r;
    assign o_in_service = in_service_r;
    assign o_isr_id     = isr_id_r;
    assign o_pending    = pending_r;

endmodule

// File: tb/tb_ext_irq_arbiter.sv
// Directed self-checking bench for ext_irq_arbiter (default parameters).
// Inputs change 1 time unit after a rising edge, and outputs are sampled there.
// Edge counts below are counted from the first edge that sees a new input.
module tb_ext_irq_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_src;
    logic [7:0] irq_en;
    logic [7:0] level_mode;
    logic       claim;
    logic       complete;
    logic       meip;
    logic [3:0] vecto_no;
    logic       in_service;
    logic [3:0] isr_id;
    logic [7:0] pending;

    int errors;
    int checks;

    ext_irq_arbiter #(.N_SRC(8), .SYNC_STAGES(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq_src    (irq_src),
        .i_irq_en     (irq_en),
        .i_level_mode (level_mode),
        .i_claim      (claim),
        .i_complete   (complete),
        .o_meip       (meip),
        .o_vecto_no   (vecto_no),
        .o_in_service (in_service),
        .o_isr_id     (isr_id),
        .o_pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL rst_meip: got %0d expected 0", meip); end
        checks++; if (vecto_no !== 4'd0) begin errors++; $display("FAIL rst_vecto: got %0d expected 0", vecto_no); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rst_insvc: got %0d expected 0", in_service); end
        checks++; if (isr_id !== 4'd0) begin errors++; $display("FAIL rst_isr: got %0d expected 0", isr_id); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_pending: got %0h expected 00", pending); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_edge_capture();
        irq_src[3] = 1'b1;
        tick(3);
        checks++; if (pending !== 8'h08) begin errors++; $display("FAIL edge_pend3: got %0h expected 08", pending); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL edge_meip_early: got %0d expected 0", meip); end
        tick(1);
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL edge_meip: got %0d expected 1", meip); end
        checks++; if (vecto_no !== 4'd4) begin errors++; $display("FAIL edge_vecto: got %0d expected 4", vecto_no); end
        claim = 1'b1; tick(1); claim = 1'b0;
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL edge_insvc: got %0d expected 1", in_service); end
        checks++; if (isr_id !== 4'd4) begin errors++; $display("FAIL edge_isr: got %0d expected 4", isr_id); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL edge_meip_svc: got %0d expected 0", meip); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL edge_pend_clr: got %0h expected 00", pending); end
        checks++; if (vecto_no !== 4'd4) begin errors++; $display("FAIL edge_vecto_hold: got %0d expected 4", vecto_no); end
        irq_src[3] = 1'b0;
        tick(3);
        complete = 1'b1; tick(1); complete = 1'b0;
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL edge_done_insvc: got %0d expected 0", in_service); end
        checks++; if (isr_id !== 4'd0) begin errors++; $display("FAIL edge_done_isr: got %0d expected 0", isr_id); end
        checks++; if (vecto_no !== 4'd0) begin errors++; $display("FAIL edge_done_vecto: got %0d expected 0", vecto_no); end
        tick(2);
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL edge_no_rereq: got %0d expected 0", meip); end
    endtask

    task automatic test_priority();
        irq_src[5] = 1'b1;
        tick(4);
        checks++; if (vecto_no !== 4'd6) begin errors++; $display("FAIL prio_vecto6: got %0d expected 6", vecto_no); end
        irq_src[1] = 1'b1;
        tick(3);
        checks++; if (vecto_no !== 4'd6) begin errors++; $display("FAIL prio_vecto6_hold: got %0d expected 6", vecto_no); end
        tick(1);
        checks++; if (vecto_no !== 4'd2) begin errors++; $display("FAIL prio_vecto2: got %0d expected 2", vecto_no); end
        claim = 1'b1; tick(1); claim = 1'b0;
        checks++; if (isr_id !== 4'd2) begin errors++; $display("FAIL prio_isr2: got %0d expected 2", isr_id); end
        checks++; if (pending !== 8'h20) begin errors++; $display("FAIL prio_pend: got %0h expected 20", pending); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL prio_meip_svc: got %0d expected 0", meip); end
        irq_src = 8'h00;
        tick(2);
        complete = 1'b1; tick(1); complete = 1'b0;
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL prio_idle_gap: got %0d expected 0", meip); end
        tick(1);
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL prio_rereq: got %0d expected 1", meip); end
        checks++; if (vecto_no !== 4'd6) begin errors++; $display("FAIL prio_rereq_vecto: got %0d expected 6", vecto_no); end
        claim = 1'b1; tick(1); claim = 1'b0;
        complete = 1'b1; tick(1); complete = 1'b0;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL prio_end_pend: got %0h expected 00", pending); end
    endtask

    task automatic test_masking();
        irq_en = 8'hFB;
        irq_src[2] = 1'b1;
        tick(5);
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL mask_meip: got %0d expected 0", meip); end
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL mask_pend: got %0h expected 04", pending); end
        irq_en = 8'hFF;
        tick(1);
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL mask_en_meip: got %0d expected 1", meip); end
        checks++; if (vecto_no !== 4'd3) begin errors++; $display("FAIL mask_en_vecto: got %0d expected 3", vecto_no); end
        irq_en = 8'hFB;
        tick(1);
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL mask_drop_meip: got %0d expected 0", meip); end
        checks++; if (vecto_no !== 4'd0) begin errors++; $display("FAIL mask_drop_vecto: got %0d expected 0", vecto_no); end
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL mask_drop_pend: got %0h expected 04", pending); end
        irq_en = 8'hFF;
        irq_src[2] = 1'b0;
        tick(1);
        claim = 1'b1; tick(1); claim = 1'b0;
        checks++; if (isr_id !== 4'd3) begin errors++; $display("FAIL mask_isr: got %0d expected 3", isr_id); end
        complete = 1'b1; tick(1); complete = 1'b0;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL mask_end_pend: got %0h expected 00", pending); end
    endtask

    task automatic test_level_edge_service();
        level_mode[0] = 1'b1;
        irq_src[0] = 1'b1;
        tick(4);
        checks++; if (vecto_no !== 4'd1) begin errors++; $display("FAIL lvl_vecto: got %0d expected 1", vecto_no); end
        claim = 1'b1; tick(1); claim = 1'b0;
        checks++; if (pending !== 8'h01) begin errors++; $display("FAIL lvl_pend_kept: got %0h expected 01", pending); end
        tick(2);
        complete = 1'b1; tick(1); complete = 1'b0;
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL lvl_gap: got %0d expected 0", meip); end
        tick(1);
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL lvl_rereq: got %0d expected 1", meip); end
        checks++; if (vecto_no !== 4'd1) begin errors++; $display("FAIL lvl_rereq_vecto: got %0d expected 1", vecto_no); end
        irq_src[0] = 1'b0;
        tick(3);
        claim = 1'b1; tick(1); claim = 1'b0;
        complete = 1'b1; tick(1); complete = 1'b0;
        tick(1);
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL lvl_low_norereq: got %0d expected 0", meip); end
        // Edge mode, no new edge during service.
        level_mode[0] = 1'b0;
        irq_src[0] = 1'b1;
        tick(4);
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL edg0_meip: got %0d expected 1", meip); end
        claim = 1'b1; tick(1); claim = 1'b0;
        complete = 1'b1; tick(1); complete = 1'b0;
        tick(2);
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL edg0_norereq: got %0d expected 0", meip); end
        // Edge mode, a new edge is captured during service.
        irq_src[0] = 1'b0;
        tick(3);
        irq_src[0] = 1'b1;
        tick(4);
        claim = 1'b1; tick(1); claim = 1'b0;
        irq_src[0] = 1'b0;
        tick(3);
        irq_src[0] = 1'b1;
        tick(3);
        checks++; if (pending !== 8'h01) begin errors++; $display("FAIL edg0_svc_pend: got %0h expected 01", pending); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL edg0_svc_nonest: got %0d expected 0", meip); end
        complete = 1'b1; tick(1); complete = 1'b0;
        tick(1);
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL edg0_rereq: got %0d expected 1", meip); end
        checks++; if (vecto_no !== 4'd1) begin errors++; $display("FAIL edg0_rereq_vecto: got %0d expected 1", vecto_no); end
        irq_src[0] = 1'b0;
        claim = 1'b1; tick(1); claim = 1'b0;
        complete = 1'b1; tick(1); complete = 1'b0;
        tick(2);
    endtask

    task automatic test_handshake();
        claim = 1'b1; tick(1); claim = 1'b0;
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL hs_idle_claim: got %0d expected 0", in_service); end
        checks++; if (isr_id !== 4'd0) begin errors++; $display("FAIL hs_idle_isr: got %0d expected 0", isr_id); end
        irq_src[4] = 1'b1;
        tick(4);
        checks++; if (vecto_no !== 4'd5) begin errors++; $display("FAIL hs_vecto5: got %0d expected 5", vecto_no); end
        complete = 1'b1; tick(1); complete = 1'b0;
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL hs_req_complete: got %0d expected 1", meip); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL hs_req_insvc: got %0d expected 0", in_service); end
        irq_src[4] = 1'b0;
        tick(3);
        irq_src[4] = 1'b1;
        tick(2);
        // The rising edge sets pending on the same edge that accepts the claim.
        claim = 1'b1; tick(1); claim = 1'b0;
        checks++; if (pending !== 8'h10) begin errors++; $display("FAIL hs_coincident_pend: got %0h expected 10", pending); end
        checks++; if (isr_id !== 4'd5) begin errors++; $display("FAIL hs_coincident_isr: got %0d expected 5", isr_id); end
        complete = 1'b1; tick(1); complete = 1'b0;
        tick(1);
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL hs_rereq: got %0d expected 1", meip); end
        irq_src[4] = 1'b0;
        claim = 1'b1; tick(1); claim = 1'b0;
        complete = 1'b1; tick(1); complete = 1'b0;
        tick(2);
    endtask

    task automatic test_async_reset();
        irq_src[6] = 1'b1;
        tick(4);
        checks++; if (vecto_no !== 4'd7) begin errors++; $display("FAIL ar_vecto7: got %0d expected 7", vecto_no); end
        claim = 1'b1; tick(1); claim = 1'b0;
        irq_src[3] = 1'b1;
        tick(3);
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL ar_insvc: got %0d expected 1", in_service); end
        checks++; if (pending !== 8'h08) begin errors++; $display("FAIL ar_pend_pre: got %0h expected 08", pending); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL ar_now_insvc: got %0d expected 0", in_service); end
        checks++; if (isr_id !== 4'd0) begin errors++; $display("FAIL ar_now_isr: got %0d expected 0", isr_id); end
        checks++; if (vecto_no !== 4'd0) begin errors++; $display("FAIL ar_now_vecto: got %0d expected 0", vecto_no); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL ar_now_pend: got %0h expected 00", pending); end
        tick(2);
        irq_src = 8'h00;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL ar_post_meip: got %0d expected 0", meip); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL ar_post_pend: got %0h expected 00", pending); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL ar_post_insvc: got %0d expected 0", in_service); end
        complete = 1'b1; tick(1); complete = 1'b0;
        irq_src[2] = 1'b1;
        tick(4);
        checks++; if (vecto_no !== 4'd3) begin errors++; $display("FAIL ar_idle_req: got %0d expected 3", vecto_no); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        irq_src    = 8'h00;
        irq_en     = 8'hFF;
        level_mode = 8'h00;
        claim      = 1'b0;
        complete   = 1'b0;
        test_reset();
        test_edge_capture();
        test_priority();
        test_masking();
        test_level_edge_service();
        test_handshake();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_irq_arbiter.md
Name: ext_irq_arbiter

Overview:
- Upstream feeder of the machine controller's external-interrupt path.
- Synchronises up to 8 external IRQ lines and latches them as pending in edge or level mode.
- Arbitrates by fixed priority and drives registered meip/vecto_no to the controller.
- Runs a claim/complete handshake: the trap entry (intr_en) claims the request; mret (mret_status) completes it.

Parameters:
- N_SRC, 8, number of IRQ sources; legal range 1..8. Source k maps to vecto_no k+1.
- SYNC_STAGES, 2, flops per input synchroniser; minimum 2.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_irq_src  in  N_SRC  raw asynchronous interrupt lines, active-high
- i_irq_en  in  N_SRC  per-source enable mask
- i_level_mode  in  N_SRC  1 = level-sensitive, 0 = rising-edge
- i_claim  in  1  one-cycle pulse: trap taken for the external interrupt (controller intr_en)
- i_complete  in  1  one-cycle pulse: handler returned (controller mret_status)
- o_meip  out  1  external interrupt request to the controller
- o_vecto_no  out  4  winning source ID (1..N_SRC); 0 = none
- o_in_service  out  1  a claimed interrupt is being serviced
- o_isr_id  out  4  ID latched at claim; 0 when not in service
- o_pending  out  N_SRC  raw pending bits, for debug/CSR readback

Behaviour:
- Reset is asynchronous, active-low on i_rst_n; clock is i_clk. Reset clears all synchronisers, edge history, pending bits, the FSM (to IDLE) and every output to 0. The same applies on reset mid-operation, including during SERVICE.
- Synchroniser: SYNC_STAGES flops per source. The last stage, s[k], is the only value used internally.
- Pending set, edge mode: s[k]=1 and the previous s[k]=0.
- Pending set, level mode: s[k]=1.
- Pending clear: on i_claim accepted in REQUEST, only for the source equal to o_vecto_no. Set has priority over clear in the same cycle, so a new edge coinciding with the claim is retained.
- Pending bits are independent of i_irq_en. Masking affects arbitration only.
- Candidate vector: cand = pending & i_irq_en. During SERVICE the in-service source is also excluded. There is no nesting: meip stays low in SERVICE regardless of cand.
- Winner: the lowest index k with cand[k]=1; win_id = k+1, or 0 if cand is empty.
- FSM states: IDLE, REQUEST, SERVICE.
  - IDLE → REQUEST when cand ≠ 0.
  - REQUEST → SERVICE on i_claim.
  - REQUEST → IDLE when cand becomes 0 with no claim, e.g. the enable is cleared.
  - SERVICE → IDLE on i_complete.
  - i_claim outside REQUEST is ignored. i_complete outside SERVICE is ignored.
  - i_claim and cand=0 in the same REQUEST cycle: the claim wins; the FSM enters SERVICE with the registered o_vecto_no.
- Outputs are all registered:
  - o_meip = 1 exactly while in REQUEST.
  - o_vecto_no is updated every cycle while in REQUEST, so a higher-priority arrival before the claim replaces it. It is held while in SERVICE and is 0 in IDLE.
  - The claim latches o_isr_id = o_vecto_no and sets o_in_service on the transition into SERVICE. Both are cleared on the transition out of SERVICE.
- Latency, from i_irq_src rising (sampled at edge 0):
  - s[k]=1 after SYNC_STAGES edges.
  - Pending set 1 edge later.
  - o_meip/o_vecto_no valid 1 edge after that, i.e. SYNC_STAGES+2 edges total (4 with defaults).
- After i_complete, a source still pending (edge captured during service, or level still high) re-requests: IDLE for 1 cycle, then REQUEST.
- Pulses shorter than 1 clock are not guaranteed to be captured.

Test Plan:
- Edge capture: raise src3 (edge mode, enabled) at edge 0 → o_pending[3]=1 at edge 3; o_meip=1 and o_vecto_no=4 at edge 4. Claim → o_in_service=1, o_isr_id=4, o_meip=0, o_pending[3]=0. Complete → all outputs return to 0.
- Priority: src5 pending in REQUEST, then src1 arrives before the claim → o_vecto_no changes from 6 to 2. Claim → o_isr_id=2; after complete, meip re-asserts with o_vecto_no=6.
- Masking: src2 pending with i_irq_en[2]=0 → o_meip stays 0 and o_pending[2]=1. Set the enable → o_meip=1, o_vecto_no=3. Clear the enable while in REQUEST with no claim → FSM returns to IDLE, o_meip=0.
- Level vs edge during service: src0 in level mode held high through service → after complete, meip re-asserts with vecto 1. Repeat in edge mode with no new edge → no re-request. Add a new edge during service → re-request after complete.
- Handshake corners: i_claim in IDLE and i_complete in REQUEST → no state change. A src4 edge coincident with its own claim → o_pending[4] stays 1.
- Async reset asserted mid-SERVICE → all outputs 0 immediately, without waiting for a clock edge. After release → FSM in IDLE with pending cleared.
